// File: rtl/god_bless_apollo_clkdiv_pkg.sv
// Shared types and defaults for the god_bless_apollo clock divider.
// Holds the lock FSM state encoding and a small index-width helper.
package god_bless_apollo_clkdiv_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int LOCK_CYCLES_DEF = 64;

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/god_bless_apollo_clkdiv_ch.sv
// One divider channel: a wrapping phase counter with registered
// square-wave and rising-edge enable outputs.
module god_bless_apollo_clkdiv_ch
  import god_bless_apollo_clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             active_next,
  input  logic [CNT_W-1:0] div,
  output logic             outclk,
  output logic             outclk_en
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // The counter restarts at zero on entry to lock, so every channel
  // leaves the settle period phase-aligned.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves
    // cnt_next unassigned, which would infer a latch.
    cnt_next = '0;
    if (active && active_next && (cnt != div - 1'b1)) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Outputs are computed from cnt_next so they line up with cnt in the
  // cycle they are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples the pre-edge values, independent of statement order.
      cnt       <= cnt_next;
      outclk    <= active_next && (cnt_next < (div >> 1));
      outclk_en <= active_next && (cnt_next == '0);
    end
  end

endmodule

// File: rtl/god_bless_apollo_clkdiv.sv
// Multi-channel integer clock divider with a settle-then-lock FSM and a
// valid/ready reconfiguration port for per-channel divide ratios.
module god_bless_apollo_clkdiv
  import god_bless_apollo_clkdiv_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      CNT_W       = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT    = {16'd2, 16'd8},
  parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [idx_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic                      cfg_err,
  output logic [NUM_CH-1:0]         outclk,
  output logic [NUM_CH-1:0]         outclk_en,
  output logic                      locked
);

  localparam int LK_W = idx_w(LOCK_CYCLES);

  state_e           state;
  logic [LK_W-1:0]  lock_cnt;
  logic [CNT_W-1:0] div_q [NUM_CH];

  logic active;
  logic active_next;
  logic handshake;
  logic legal;
  logic lock_done;

  assign active    = (state == LOCKED);
  assign cfg_ready = active;
  assign locked    = active;
  assign handshake = cfg_valid && active;
  assign legal     = (cfg_div >= CNT_W'(2)) && (int'(cfg_ch) < NUM_CH);
  assign lock_done = (lock_cnt == LK_W'(LOCK_CYCLES - 1));

  // A legal request drops every channel back into the settle period.
  assign active_next = active ? !(handshake && legal) : lock_done;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      cfg_err  <= 1'b0;
      // NOTE: the ratio table is a handful of flops, not a RAM, so it is
      // reset to DIV_INIT; this is what discards runtime reconfiguration.
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
    end else begin
      cfg_err <= handshake && !legal;
      case (state)
        LOCKING: begin
          if (lock_done) begin
            state    <= LOCKED;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (handshake && legal) begin
            state    <= LOCKING;
            lock_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (int'(cfg_ch) == i) div_q[i] <= cfg_div;
            end
          end
        end
        default: state <= LOCKING;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    god_bless_apollo_clkdiv_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (refclk),
      .rst_n       (rst),
      .active      (active),
      .active_next (active_next),
      .div         (div_q[g]),
      .outclk      (outclk[g]),
      .outclk_en   (outclk_en[g])
    );
  end

endmodule

// File: tb/tb_god_bless_apollo_clkdiv.sv
// Directed bench for god_bless_apollo_clkdiv: default two-channel instance
// plus a three-channel instance for out-of-range channel requests.
module tb_god_bless_apollo_clkdiv;

  logic        refclk = 1'b0;
  logic        rst    = 1'b0;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_err;
  logic [1:0]  outclk;
  logic [1:0]  outclk_en;
  logic        locked;

  logic        cfg_valid_b;
  logic        cfg_ready_b;
  logic [1:0]  cfg_ch_b;
  logic [7:0]  cfg_div_b;
  logic        cfg_err_b;
  logic [2:0]  outclk_b;
  logic [2:0]  outclk_en_b;
  logic        locked_b;

  int checks   = 0;
  int failures = 0;
  int t;
  int n;

  always #5 refclk = ~refclk;

  god_bless_apollo_clkdiv dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  god_bless_apollo_clkdiv #(
    .NUM_CH      (3),
    .CNT_W       (8),
    .DIV_INIT    ({8'd3, 8'd4, 8'd2}),
    .LOCK_CYCLES (4)
  ) dut_b (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid_b),
    .cfg_ready (cfg_ready_b),
    .cfg_ch    (cfg_ch_b),
    .cfg_div   (cfg_div_b),
    .cfg_err   (cfg_err_b),
    .outclk    (outclk_b),
    .outclk_en (outclk_en_b),
    .locked    (locked_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // {en, outclk} of one channel, t cycles after the first locked cycle.
  function automatic logic [1:0] phase(input int tt, input int d);
    return {((tt % d) == 0), ((tt % d) < (d / 2))};
  endfunction

  function automatic logic [3:0] exp_a(input int tt, input int d0, input int d1);
    logic [1:0] p0;
    logic [1:0] p1;
    p0 = phase(tt, d0);
    p1 = phase(tt, d1);
    return {p1[1], p0[1], p1[0], p0[0]};
  endfunction

  function automatic logic [5:0] exp_b(input int tt, input int d0, input int d1, input int d2);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    p0 = phase(tt, d0);
    p1 = phase(tt, d1);
    p2 = phase(tt, d2);
    return {p2[1], p1[1], p0[1], p2[0], p1[0], p0[0]};
  endfunction

  task automatic run_wave(input string tag, input int cycles, input int d0, input int d1);
    for (int k = 0; k < cycles; k++) begin
      step();
      t++;
      check(tag, {outclk_en, outclk}, exp_a(t, d0, d1));
    end
  endtask

  task automatic lock_and_wave(input string tag, input int latency, input int cycles,
                               input int d0, input int d1);
    int cnt = 0;
    while (locked !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, latency);
    t = 0;
    check({tag, "_first"}, {outclk_en, outclk}, 4'b1111);
    run_wave({tag, "_wave"}, cycles, d0, d1);
  endtask

  initial begin
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_div     = '0;
    cfg_valid_b = 1'b0;
    cfg_ch_b    = '0;
    cfg_div_b   = '0;

    repeat (3) step();
    check("rst_out",   {outclk_en, outclk}, 4'b0000);
    check("rst_locked", locked,    1'b0);
    check("rst_ready",  cfg_ready, 1'b0);
    check("rst_err",    cfg_err,   1'b0);

    rst = 1'b1;
    lock_and_wave("init", 64, 8, 8, 2);

    // Rejected requests: ratio below 2 on either channel.
    cfg_valid = 1'b1; cfg_ch = 1'd0; cfg_div = 16'd1;
    run_wave("div1_wave", 1, 8, 2);
    cfg_valid = 1'b0;
    check("div1_err",    cfg_err, 1'b1);
    check("div1_locked", locked,  1'b1);
    run_wave("div1_wave", 1, 8, 2);
    check("div1_err_clr", cfg_err, 1'b0);
    cfg_valid = 1'b1; cfg_ch = 1'd1; cfg_div = 16'd0;
    run_wave("div0_wave", 1, 8, 2);
    cfg_valid = 1'b0;
    check("div0_err", cfg_err, 1'b1);
    run_wave("div0_wave", 4, 8, 2);

    // Legal reconfiguration of ch0 to 5.
    cfg_valid = 1'b1; cfg_ch = 1'd0; cfg_div = 16'd5;
    step();
    cfg_valid = 1'b0;
    check("recfg_locked", locked,    1'b0);
    check("recfg_out",    {outclk_en, outclk}, 4'b0000);
    check("recfg_ready",  cfg_ready, 1'b0);
    check("recfg_err",    cfg_err,   1'b0);
    lock_and_wave("div5", 64, 15, 5, 2);

    // Request held through LOCKING is ignored until the first locked cycle.
    cfg_valid = 1'b1; cfg_ch = 1'd1; cfg_div = 16'd3;
    step();
    cfg_div = 16'd4;
    check("held_enter", locked, 1'b0);
    repeat (30) step();
    check("held_ready", cfg_ready, 1'b0);
    check("held_err",   cfg_err,   1'b0);
    check("held_out",   {outclk_en, outclk}, 4'b0000);
    n = 0;
    while (locked !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("held_latency", n, 34);
    check("held_ready_lk", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("held_accept", locked, 1'b0);
    check("held_no_err", cfg_err, 1'b0);
    lock_and_wave("div5_4", 64, 12, 5, 4);

    // Reset during LOCKING discards all runtime ratios.
    cfg_valid = 1'b1; cfg_ch = 1'd0; cfg_div = 16'd5;
    step();
    cfg_valid = 1'b0;
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out",    {outclk_en, outclk}, 4'b0000);
    check("rst_mid_locked", locked, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    lock_and_wave("revert", 64, 16, 8, 2);

    // Asynchronous reset while LOCKED with outputs high (t=16: all ones).
    #2 rst = 1'b0;
    #1;
    check("async_out",    {outclk_en, outclk}, 4'b0000);
    check("async_locked", locked, 1'b0);

    // Three-channel instance: ratios 2/4/3, 4-cycle settle.
    step();
    rst = 1'b1;
    n = 0;
    while (locked_b !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("b_latency", n, 4);
    for (int k = 0; k < 7; k++) begin
      check("b_wave", {outclk_en_b, outclk_b}, exp_b(k, 2, 4, 3));
      step();
    end
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd4;
    step();
    cfg_valid_b = 1'b0;
    check("b_ch_err",    cfg_err_b, 1'b1);
    check("b_ch_locked", locked_b,  1'b1);
    step();
    check("b_ch_err_clr", cfg_err_b, 1'b0);
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd2; cfg_div_b = 8'd6;
    step();
    cfg_valid_b = 1'b0;
    check("b_recfg_locked", locked_b,  1'b0);
    check("b_recfg_err",    cfg_err_b, 1'b0);
    n = 0;
    while (locked_b !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("b_recfg_latency", n, 4);
    for (int k = 0; k < 8; k++) begin
      check("b_wave6", {outclk_en_b, outclk_b}, exp_b(k, 2, 4, 6));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
